// File: rtl/stepper_phase_sequencer.sv
// Stepper phase sequencer: turns the motor PIO control word into timed
// half/full-step coil patterns for a 4-phase unipolar stepper. It also
// tracks a signed half-step position that wraps.
module stepper_phase_sequencer #(
    parameter int unsigned SLOW_DIV    = 50000,
    parameter int unsigned FAST_DIV    = 12500,
    parameter bit          HOLD_TORQUE = 1'b0,
    parameter int unsigned POS_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       ctrl_in,
    output logic [3:0]       coil,
    output logic             step_pulse,
    output logic [2:0]       phase,
    output logic [POS_W-1:0] position
);

    localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned TW      = $clog2(MAX_DIV);

    localparam logic [TW-1:0] SLOW_M1 = TW'(SLOW_DIV - 1);
    localparam logic [TW-1:0] FAST_M1 = TW'(FAST_DIV - 1);

    // Control word fields, all taken from the registered copy
    logic [3:0]       ctrl_q;
    logic             en, dir_fwd, half_mode, fast_mode;

    logic [TW-1:0]    timer_q, timer_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       coil_q, coil_d;
    logic             step_pulse_q, step_pulse_d;
    logic [POS_W-1:0] position_q, position_d;

    logic [TW-1:0]    div_m1;
    logic             step_evt;
    logic [3:0]       table_pattern;
    logic signed [2:0] move;

    assign en        = ctrl_q[0];
    assign dir_fwd   = ctrl_q[1];
    assign half_mode = ctrl_q[2];
    assign fast_mode = ctrl_q[3];

    // Step-rate timer: period follows the speed bit every cycle, and the
    // >= compare lets a slow->fast switch fire immediately instead of stalling.
    always_comb begin
        div_m1   = fast_mode ? FAST_M1 : SLOW_M1;
        step_evt = en && (timer_q >= div_m1);
        if (!en) begin
            timer_d = '0;
        end else if (step_evt) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Phase move as a signed index distance. Full-step moves land on even
    // indices: an odd phase realigns by one, an even phase moves by two.
    always_comb begin
        if (half_mode) begin
            move = dir_fwd ? 3'sd1 : -3'sd1;
        end else if (dir_fwd) begin
            move = phase_q[0] ? 3'sd1 : 3'sd2;
        end else begin
            move = phase_q[0] ? -3'sd1 : -3'sd2;
        end
    end

    // Next phase/position/strobe, applied only on a step event
    always_comb begin
        phase_d      = phase_q;
        position_d   = position_q;
        step_pulse_d = 1'b0;
        if (step_evt) begin
            phase_d      = phase_q + 3'(move);
            position_d   = position_q + POS_W'(move);
            step_pulse_d = 1'b1;
        end
    end

    // Half-step coil table indexed by the current (pre-update) phase
    always_comb begin
        case (phase_q)
            3'd0:    table_pattern = 4'b0001;
            3'd1:    table_pattern = 4'b0011;
            3'd2:    table_pattern = 4'b0010;
            3'd3:    table_pattern = 4'b0110;
            3'd4:    table_pattern = 4'b0100;
            3'd5:    table_pattern = 4'b1100;
            3'd6:    table_pattern = 4'b1000;
            default: table_pattern = 4'b1001;
        endcase
        coil_d = (en || HOLD_TORQUE) ? table_pattern : '0;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= '0;
            timer_q      <= '0;
            phase_q      <= '0;
            coil_q       <= '0;
            step_pulse_q <= 1'b0;
            position_q   <= '0;
        end else begin
            ctrl_q       <= ctrl_in;
            timer_q      <= timer_d;
            phase_q      <= phase_d;
            coil_q       <= coil_d;
            step_pulse_q <= step_pulse_d;
            position_q   <= position_d;
        end
    end

    assign coil       = coil_q;
    assign step_pulse = step_pulse_q;
    assign phase      = phase_q;
    assign position   = position_q;

endmodule
